spi_master_reg_xfer: RTL

//   SPI master (mode 0, MSB first) that runs one register transaction against the
//   SPI register-slave: a command byte {rw, 5'b0, addr[1:0]}, then one data byte.

---
 rtl/spi_master_reg_xfer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_reg_xfer.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_reg_xfer
// Brief    : SPI mode-0, MSB-first master that runs one register transaction
//            (command byte {rw,5'b0,addr} followed by one data byte) against
//            an SPI register slave. Writes send wdata; reads capture MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_reg_xfer #(
    parameter int CLK_DIV = 4,   // clk cycles per SCLK half-period (>= 4)
    parameter int GAP_CYC = 8    // clk cycles of SCLK low between the two bytes
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       busy,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS
);

    // Single phase counter is shared by every timed state, so it must reach
    // the longer of the half-period and the inter-byte gap.
    localparam int c_MAX_CNT = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOW     = 3'd1;
    localparam logic [2:0] c_ST_HIGH    = 3'd2;
    localparam logic [2:0] c_ST_GAP     = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;
    localparam logic [2:0] c_ST_RECOVER = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nx;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [2:0]         r_bit_cnt;
    logic               r_byte_cnt;
    logic [7:0]         r_tx_sh;
    // Only seven bits are held: the eighth received bit is taken straight
    // from MISO when the byte completes.
    logic [6:0]         r_rx_sh;
    logic [7:0]         r_wdata_q;
    logic               r_rw_q;
    logic [7:0]         r_rdata;
    logic               r_done;
    logic               r_busy;
    logic               r_sclk;
    logic               r_ss;

    logic               w_div_last;
    logic               w_gap_last;
    logic               w_bit_end;

    assign w_div_last = (r_div_cnt == c_DIV_LAST);
    assign w_gap_last = (r_div_cnt == c_GAP_LAST);
    assign w_bit_end  = (r_state == c_ST_HIGH) && w_div_last;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode: each timed state leaves on the last cycle of its count.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nx = c_ST_LOW;
                end
            end
            c_ST_LOW: begin
                if (w_div_last) begin
                    w_state_nx = c_ST_HIGH;
                end
            end
            c_ST_HIGH: begin
                if (w_div_last) begin
                    if (r_bit_cnt != 3'd7) begin
                        w_state_nx = c_ST_LOW;
                    end else if (!r_byte_cnt) begin
                        w_state_nx = c_ST_GAP;
                    end else begin
                        w_state_nx = c_ST_HOLD;
                    end
                end
            end
            c_ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nx = c_ST_LOW;
                end
            end
            c_ST_HOLD: begin
                if (w_div_last) begin
                    w_state_nx = c_ST_RECOVER;
                end
            end
            c_ST_RECOVER: begin
                if (w_div_last) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase
    end

    // Registered pin/status outputs follow the state being entered, so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk <= 1'b0;
            r_ss   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sclk <= (w_state_nx == c_ST_HIGH);
            r_ss   <= (w_state_nx == c_ST_IDLE) || (w_state_nx == c_ST_RECOVER);
            r_busy <= (w_state_nx != c_ST_IDLE);
            r_done <= (r_state == c_ST_HOLD) && w_div_last;
        end
    end

    // Phase counter restarts whenever a state is entered and rests at 0 in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) || (w_state_nx != r_state)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_CNT_ONE;
        end
    end

    // Transaction datapath: request latch, shift registers and bit/byte counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_sh    <= 8'h00;
            r_rx_sh    <= 7'h00;
            r_wdata_q  <= 8'h00;
            r_rw_q     <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 1'b0;
            r_rdata    <= 8'h00;
        end else begin
            if ((r_state == c_ST_IDLE) && start) begin
                r_tx_sh    <= {rw, 5'b0, addr};
                r_wdata_q  <= wdata;
                r_rw_q     <= rw;
                r_rx_sh    <= 7'h00;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 1'b0;
            end else if (w_bit_end) begin
                // MISO is sampled in the last clk of the high phase, just
                // before SCLK falls and the next MOSI bit is presented.
                r_rx_sh   <= {r_rx_sh[5:0], MISO};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt != 3'd7) begin
                    r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                end else if (!r_byte_cnt) begin
                    // Reads clock out zeros in the data byte.
                    r_tx_sh    <= r_rw_q ? r_wdata_q : 8'h00;
                    r_byte_cnt <= 1'b1;
                end else begin
                    r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                    r_rdata <= {r_rx_sh, MISO};
                end
            end
        end
    end

    // MOSI tracks the shift register MSB only while the slave is selected.
    assign MOSI  = ~r_ss & r_tx_sh[7];
    assign SCLK  = r_sclk;
    assign SS    = r_ss;
    assign busy  = r_busy;
    assign done  = r_done;
    assign rdata = r_rdata;

endmodule
`default_nettype wire
